// File: rtl/axis2fib_pkg.sv
// Shared types, descriptor/statistics field positions and strobe helper for
// the FMAC receive FIFO to AXI-Stream bridge.
package axis2fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CNT,
    ST_DESC,
    ST_STREAM
  } state_t;

  localparam int unsigned BCNT_HI  = 31;
  localparam int unsigned BCNT_LO  = 16;
  localparam int unsigned ERR_BIT  = 15;
  localparam int unsigned FILT_BIT = 14;

  localparam int unsigned STAT_BCNT_LO = 0;
  localparam int unsigned STAT_BCNT_HI = 15;
  localparam int unsigned STAT_TUSER   = 16;
  localparam int unsigned STAT_FILT    = 17;
  localparam int unsigned STAT_SEQ_LO  = 18;
  localparam int unsigned STAT_SEQ_HI  = 27;

  // Widest supported beat is 512 bits.
  localparam int unsigned MAX_BYTES = 64;

  // Byte mask of the final beat: low (bcnt mod BYTES) lanes, or all lanes.
  function automatic logic [MAX_BYTES-1:0] last_strb(input logic [15:0] bcnt,
                                                     input int unsigned BYTES);
    int unsigned rem;
    logic [MAX_BYTES-1:0] m;
    rem = 32'(bcnt) % BYTES;
    m   = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      m[i] = (i < BYTES) && ((rem == 0) || (i < rem));
    return m;
  endfunction

endpackage

// File: rtl/axis2fib_skid_buf.sv
// Two-entry FIFO that decouples FIFO read latency from AXIS back-pressure.
module axis2fib_skid_buf
  import axis2fib_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && (count != 2'd2);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis2fib_rx_streamer.sv
// Pops a frame descriptor from the count FIFO and streams the frame from the
// data FIFO as AXIS beats with tstrb/tlast, plus a per-frame statistics pulse.
module axis2fib_rx_streamer
  import axis2fib_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned BCNT_WIDTH      = 32,
  parameter int unsigned MAX_FRAME_BYTES = 9600
) (
  input  logic                    rx_mac_aclk,
  input  logic                    reset_,
  output logic                    rden_rf,
  output logic                    rden_rcf,
  input  logic                    rdempty_rf,
  input  logic                    rdempty_rcf,
  input  logic [DATA_WIDTH-1:0]   dataout_rf,
  input  logic [BCNT_WIDTH-1:0]   dataout_rcf,
  output logic [DATA_WIDTH-1:0]   rx_axis_mac_tdata,
  output logic                    rx_axis_mac_tvalid,
  output logic                    rx_axis_mac_tlast,
  output logic                    rx_axis_mac_tuser,
  output logic                    rx_axis_filter_tuser,
  output logic [DATA_WIDTH/8-1:0] rx_axis_mac_tstrb,
  output logic [27:0]             rx_statistics_vector,
  output logic                    rx_statistics_valid,
  input  logic                    rx_axis_mac_tready,
  input  logic                    rx_axis_compatible_mode,
  output logic [15:0]             rx_zero_len_cnt,
  output logic                    test
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam int unsigned PAY_W = DATA_WIDTH + BYTES + 3;

  state_t               state, state_nxt;
  logic                 rdy, pop, rd_inflight, space_ok, last_read;
  logic [1:0]           occ;
  logic [15:0]          desc_bcnt, desc_beats, beats_left, frame_bcnt;
  logic [16:0]          bcnt_round;
  logic                 desc_big, frame_user, frame_filt;
  logic                 side_last, side_user, side_filt;
  logic [BYTES-1:0]     side_strb;
  logic [MAX_BYTES-1:0] strb_full;
  logic [PAY_W-1:0]     push_data, head;
  logic [15:0]          byte_acc, beat_bytes;
  logic [9:0]           seq;
  logic                 unused_bits;

  assign test        = 1'b0;
  assign unused_bits = ^{dataout_rcf, strb_full};

  assign rdy        = rx_axis_mac_tready | rx_axis_compatible_mode;
  assign pop        = rx_axis_mac_tvalid & rdy;
  assign desc_bcnt  = dataout_rcf[BCNT_HI:BCNT_LO];
  assign bcnt_round = {1'b0, desc_bcnt} + 17'(BYTES - 1);
  assign desc_beats = 16'(bcnt_round >> SHIFT);
  assign desc_big   = 32'(desc_bcnt) > MAX_FRAME_BYTES;
  assign strb_full  = last_strb(frame_bcnt, BYTES);
  assign last_read  = (beats_left == 16'd1);
  // Credit the beat leaving this cycle so one beat per cycle can be sustained.
  assign space_ok   = ({1'b0, occ} - {2'b0, pop} + {2'b0, rd_inflight}) < 3'd2;

  always_comb begin
    state_nxt = state;
    rden_rcf  = 1'b0;
    rden_rf   = 1'b0;
    case (state)
      ST_IDLE: if (!rdempty_rcf) state_nxt = ST_CNT;
      ST_CNT: begin
        rden_rcf  = 1'b1;
        state_nxt = ST_DESC;
      end
      ST_DESC: state_nxt = (desc_bcnt == 16'd0) ? ST_IDLE : ST_STREAM;
      ST_STREAM: begin
        rden_rf = !rdempty_rf && space_ok;
        if (rden_rf && last_read) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_mac_aclk or negedge reset_) begin
    if (!reset_) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge rx_mac_aclk or negedge reset_) begin
    if (!reset_) begin
      beats_left      <= '0;
      frame_bcnt      <= '0;
      frame_user      <= 1'b0;
      frame_filt      <= 1'b0;
      rx_zero_len_cnt <= '0;
      rd_inflight     <= 1'b0;
      side_last       <= 1'b0;
      side_user       <= 1'b0;
      side_filt       <= 1'b0;
      side_strb       <= '0;
    end else begin
      if (state == ST_DESC) begin
        beats_left <= desc_beats;
        frame_bcnt <= desc_bcnt;
        frame_user <= dataout_rcf[ERR_BIT] | desc_big;
        frame_filt <= dataout_rcf[FILT_BIT];
        if (desc_bcnt == 16'd0 && rx_zero_len_cnt != 16'hFFFF)
          rx_zero_len_cnt <= rx_zero_len_cnt + 16'd1;
      end else if (rden_rf) begin
        beats_left <= beats_left - 16'd1;
      end
      // Sideband is captured at read time and paired with the data next cycle.
      rd_inflight <= rden_rf;
      if (rden_rf) begin
        side_last <= last_read;
        side_strb <= last_read ? strb_full[BYTES-1:0] : '1;
        side_user <= frame_user;
        side_filt <= frame_filt;
      end
    end
  end

  assign push_data = {dataout_rf, side_strb, side_last, side_user, side_filt};

  axis2fib_skid_buf #(.WIDTH(PAY_W)) u_skid (
    .clk       (rx_mac_aclk),
    .rst_n     (reset_),
    .in_valid  (rd_inflight),
    .in_data   (push_data),
    .out_valid (rx_axis_mac_tvalid),
    .out_data  (head),
    .out_ready (rdy),
    .count     (occ)
  );

  assign {rx_axis_mac_tdata, rx_axis_mac_tstrb, rx_axis_mac_tlast,
          rx_axis_mac_tuser, rx_axis_filter_tuser} = head;

  // Byte count is rebuilt from emitted strobes, so overlapping frames never
  // need the descriptor of a frame still draining from the buffer.
  always_comb begin
    beat_bytes = '0;
    for (int unsigned i = 0; i < BYTES; i++)
      beat_bytes = beat_bytes + 16'(rx_axis_mac_tstrb[i]);
  end

  always_ff @(posedge rx_mac_aclk or negedge reset_) begin
    if (!reset_) begin
      rx_statistics_valid  <= 1'b0;
      rx_statistics_vector <= '0;
      byte_acc             <= '0;
      seq                  <= '0;
    end else begin
      rx_statistics_valid <= pop && rx_axis_mac_tlast;
      if (pop) begin
        if (rx_axis_mac_tlast) begin
          rx_statistics_vector[STAT_BCNT_HI:STAT_BCNT_LO] <= byte_acc + beat_bytes;
          rx_statistics_vector[STAT_TUSER]                <= rx_axis_mac_tuser;
          rx_statistics_vector[STAT_FILT]                 <= rx_axis_filter_tuser;
          rx_statistics_vector[STAT_SEQ_HI:STAT_SEQ_LO]   <= seq;
          seq      <= seq + 10'd1;
          byte_acc <= '0;
        end else begin
          byte_acc <= byte_acc + beat_bytes;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis2fib_rx_streamer.sv
// Randomised bench: FIFO models feed the bridge, a frame-level reference model
// predicts every AXIS beat and statistics word.
module tb_axis2fib_rx_streamer;

  localparam int unsigned BY   = 8;
  localparam int          MAXF = 9600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_, rden_rf, rden_rcf, rdempty_rf, rdempty_rcf;
  logic [63:0] dataout_rf, tdata;
  logic [31:0] dataout_rcf;
  logic        tvalid, tlast, tuser, ftuser, svalid, tready, compat, test;
  logic [7:0]  tstrb;
  logic [27:0] svec;
  logic [15:0] zcnt;

  logic         rden_rf128, rden_rcf128, rdempty_rcf128;
  logic [127:0] dataout_rf128, tdata128;
  logic         tvalid128, tlast128, tuser128, ftuser128, svalid128, test128;
  logic [15:0]  tstrb128, zcnt128;
  logic [27:0]  svec128;

  axis2fib_rx_streamer #(.DATA_WIDTH(64), .BCNT_WIDTH(32), .MAX_FRAME_BYTES(9600)) u_dut (
    .rx_mac_aclk(clk), .reset_(reset_), .rden_rf(rden_rf), .rden_rcf(rden_rcf),
    .rdempty_rf(rdempty_rf), .rdempty_rcf(rdempty_rcf), .dataout_rf(dataout_rf),
    .dataout_rcf(dataout_rcf), .rx_axis_mac_tdata(tdata), .rx_axis_mac_tvalid(tvalid),
    .rx_axis_mac_tlast(tlast), .rx_axis_mac_tuser(tuser), .rx_axis_filter_tuser(ftuser),
    .rx_axis_mac_tstrb(tstrb), .rx_statistics_vector(svec), .rx_statistics_valid(svalid),
    .rx_axis_mac_tready(tready), .rx_axis_compatible_mode(compat),
    .rx_zero_len_cnt(zcnt), .test(test));

  axis2fib_rx_streamer #(.DATA_WIDTH(128), .BCNT_WIDTH(32), .MAX_FRAME_BYTES(9600)) u_dut128 (
    .rx_mac_aclk(clk), .reset_(reset_), .rden_rf(rden_rf128), .rden_rcf(rden_rcf128),
    .rdempty_rf(1'b0), .rdempty_rcf(rdempty_rcf128), .dataout_rf(dataout_rf128),
    .dataout_rcf(32'h0040_0000), .rx_axis_mac_tdata(tdata128), .rx_axis_mac_tvalid(tvalid128),
    .rx_axis_mac_tlast(tlast128), .rx_axis_mac_tuser(tuser128), .rx_axis_filter_tuser(ftuser128),
    .rx_axis_mac_tstrb(tstrb128), .rx_statistics_vector(svec128), .rx_statistics_valid(svalid128),
    .rx_axis_mac_tready(1'b1), .rx_axis_compatible_mode(1'b0),
    .rx_zero_len_cnt(zcnt128), .test(test128));

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
    logic        filt;
  } beat_t;

  int checks = 0, failures = 0;

  logic [31:0] cq[$];
  logic [63:0] dq[$];
  beat_t       exp_beats[$];
  logic [27:0] exp_stats[$];
  int exp_seq, exp_zero;

  int cyc = 0, rd_total, hs_total, last_cyc, gap_last, mark;
  int first_valid, first_rd, first128, b128, s128;
  bit prev_stall, after_last, hold_en, hold;
  beat_t prev_beat;
  int rmode;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    rdempty_rcf = (cq.size() == 0);
    rdempty_rf  = (dq.size() == 0) || hold;
  endtask

  task automatic add_frame(input int bcnt, input bit err, input bit filt);
    int nb, r;
    logic [7:0] ones;
    bit user;
    beat_t b;
    cq.push_back({16'(bcnt), err, filt, 14'($urandom)});
    if (bcnt == 0) begin
      exp_zero++;
    end else begin
      user = err || (bcnt > MAXF);
      nb   = (bcnt + BY - 1) / BY;
      r    = bcnt % BY;
      ones = 8'hFF;
      for (int i = 0; i < nb; i++) begin
        b.data = {$urandom, $urandom};
        dq.push_back(b.data);
        b.strb = (i == nb - 1 && r != 0) ? (ones >> (BY - r)) : ones;
        b.last = (i == nb - 1);
        b.user = user;
        b.filt = filt;
        exp_beats.push_back(b);
      end
      exp_stats.push_back({10'(exp_seq), filt, user, 16'(bcnt)});
      exp_seq++;
    end
    refresh();
  endtask

  task automatic step();
    beat_t cur, eb;
    logic rdy, rf_rd, rcf_rd, r128, c128;
    @(negedge clk);
    cyc++;
    rdy = tready | compat;
    cur = {tdata, tstrb, tlast, tuser, ftuser};
    check_eq("rf_read_when_empty", 128'(rden_rf & rdempty_rf), 128'(0));
    check_eq("rcf_read_when_empty", 128'(rden_rcf & rdempty_rcf), 128'(0));
    check_eq("outstanding_le2", 128'((rd_total - hs_total) <= 2), 128'(1));
    if (prev_stall) begin
      check_eq("stall_valid_hold", 128'(tvalid), 128'(1));
      check_eq("stall_beat_hold", 128'(cur), 128'(prev_beat));
    end
    if (tvalid && first_valid < 0) first_valid = cyc;
    if (rden_rf && first_rd < 0) first_rd = cyc;
    if (tvalid && rdy) begin
      if (exp_beats.size() == 0) check_eq("extra_beat", 128'(1), 128'(0));
      else begin
        eb = exp_beats.pop_front();
        check_eq("beat", 128'(cur), 128'(eb));
      end
      if (after_last) gap_last = cyc - last_cyc - 1;
      after_last = tlast;
      last_cyc   = cyc;
      hs_total++;
    end
    prev_stall = tvalid && !rdy;
    prev_beat  = cur;
    if (svalid) begin
      if (exp_stats.size() == 0) check_eq("extra_stats", 128'(1), 128'(0));
      else check_eq("stats_vector", 128'(svec), 128'(exp_stats.pop_front()));
    end
    if (tvalid128) begin
      b128++;
      if (first128 < 0) first128 = cyc;
      check_eq("w128_strb", 128'(tstrb128), 128'(16'hFFFF));
      check_eq("w128_last", 128'(tlast128), 128'(b128 == 4));
      check_eq("w128_data", tdata128, 128'(b128));
      check_eq("w128_user", 128'({tuser128, ftuser128}), 128'(0));
    end
    if (svalid128) s128++;
    rf_rd  = rden_rf;
    rcf_rd = rden_rcf;
    r128   = rden_rf128;
    c128   = rden_rcf128;
    if (rf_rd) rd_total++;
    @(posedge clk);
    #1;
    if (rf_rd && dq.size() > 0) dataout_rf = dq.pop_front();
    if (rcf_rd && cq.size() > 0) dataout_rcf = cq.pop_front();
    if (r128) dataout_rf128 = dataout_rf128 + 128'd1;
    if (c128) rdempty_rcf128 = 1'b1;
    case (rmode)
      0:       tready = 1'b1;
      1:       tready = !tready;
      2:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
    hold = hold_en && ($urandom_range(0, 3) == 0);
    refresh();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_stats.size() != 0 || cq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_in_budget", 128'(n < budget), 128'(1));
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    cq.delete(); dq.delete(); exp_beats.delete(); exp_stats.delete();
    dataout_rf = '0; dataout_rcf = '0; dataout_rf128 = '0; rdempty_rcf128 = 1'b1;
    exp_seq = 0; exp_zero = 0; rd_total = 0; hs_total = 0;
    prev_stall = 1'b0; after_last = 1'b0; hold = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    #1 reset_ = 1'b1;
  endtask

  initial begin
    bit seen;
    int hs0;
    reset_ = 1'b0; tready = 1'b1; compat = 1'b0; rmode = 0; hold_en = 1'b0; hold = 1'b0;
    rdempty_rcf128 = 1'b1; dataout_rf128 = '0; dataout_rf = '0; dataout_rcf = '0;
    gap_last = 99; first_valid = -1; first_rd = -1; first128 = -1; b128 = 0; s128 = 0;
    refresh();
    #2;
    check_eq("reset_ctrl", 128'({tvalid, rden_rf, rden_rcf, svalid, tlast, tuser, ftuser, test,
                                 svec, zcnt, tstrb}), 128'(0));
    check_eq("reset_tdata", 128'(tdata), 128'(0));
    do_reset();

    // 20 bytes at 64 bits: strobes FF, FF, 0F
    add_frame(20, 1'b0, 1'b0);
    wait_drain(100);

    // Latency from count FIFO going non-empty, both widths in parallel
    first_valid = -1; first_rd = -1; first128 = -1; b128 = 0;
    mark = cyc + 1;
    rdempty_rcf128 = 1'b0;
    add_frame(64, 1'b0, 1'b0);
    wait_drain(100);
    check_eq("lat_first_rden_rf", 128'(first_rd - mark), 128'(3));
    check_eq("lat_first_tvalid", 128'(first_valid - mark), 128'(5));
    check_eq("lat128_first_tvalid", 128'(first128 - mark), 128'(5));
    check_eq("w128_beats", 128'(b128), 128'(4));
    check_eq("w128_stats", 128'({s128, svec128}), 128'({32'd1, 10'd0, 2'b00, 16'd64}));
    check_eq("w128_zero", 128'({zcnt128, test128}), 128'(0));

    // tready toggling every cycle
    rmode = 1;
    add_frame(24, 1'b0, 1'b0);
    wait_drain(100);
    rmode = 0;

    // error / oversize boundaries and zero-length descriptor
    add_frame(10000, 1'b1, 1'b0);
    add_frame(9600, 1'b0, 1'b1);
    add_frame(9601, 1'b0, 1'b0);
    wait_drain(5000);
    add_frame(0, 1'b0, 1'b1);
    wait_drain(50);
    check_eq("zero_len_cnt", 128'(zcnt), 128'(1));

    // back-to-back frames after reset: sequence 0 and 1, short gap
    do_reset();
    hs0 = hs_total;
    gap_last = 99;
    add_frame(16, 1'b0, 1'b0);
    add_frame(8, 1'b0, 1'b0);
    wait_drain(100);
    check_eq("b2b_beats", 128'(hs_total - hs0), 128'(3));
    check_eq("b2b_gap_le3", 128'(gap_last <= 3), 128'(1));

    // random traffic with back-pressure and FIFO underflow
    rmode = 2; hold_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      add_frame(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 120)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 15)) step();
    end
    wait_drain(8000);
    check_eq("rand_zero_len_cnt", 128'(zcnt), 128'(exp_zero));

    // compatible mode ignores a low tready
    rmode = 3; hold_en = 1'b0; compat = 1'b1;
    add_frame(33, 1'b0, 1'b1);
    add_frame(8, 1'b1, 1'b0);
    wait_drain(200);
    compat = 1'b0; rmode = 0;

    // asynchronous reset in the middle of a frame
    add_frame(80, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = tvalid;
    end
    check_eq("midframe_tvalid_seen", 128'(seen), 128'(1));
    #2 reset_ = 1'b0;
    #1;
    check_eq("async_reset_ctrl", 128'({tvalid, rden_rf, rden_rcf, svalid, tlast, tuser, ftuser,
                                       svec, zcnt, tstrb}), 128'(0));
    check_eq("async_reset_tdata", 128'(tdata), 128'(0));
    do_reset();
    add_frame(12, 1'b0, 1'b1);
    wait_drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis2fib_rx_streamer.md
# axis2fib_rx_streamer

Parametrised receive-side bridge from the FMAC read FIFOs to an AXI-Stream master interface, and the successor to the fixed-64-bit receive controller. Pops one descriptor (byte count plus status flags) from the count FIFO and streams exactly that frame from the data FIFO as AXIS beats with correct `tstrb`/`tlast`. Supports any power-of-two data width, full `tready` back-pressure through a 2-entry output skid buffer, and back-to-back frames without idle gaps. Emits a per-frame statistics pulse.

## Interface
Parameters:
- `DATA_WIDTH`, 64: data FIFO / `tdata` width, power of two, 64..512; `BYTES = DATA_WIDTH/8`.
- `BCNT_WIDTH`, 32: count FIFO word width.
- `MAX_FRAME_BYTES`, 9600: frames longer than this are flagged in `tuser`.

Ports:
- `rx_mac_aclk`  in  1  the single clock.
- `reset_`  in  1  reset, asynchronous, active-low.
- `rden_rf`  out  1  data FIFO read enable.
- `rden_rcf`  out  1  count FIFO read enable.
- `rdempty_rf`  in  1  data FIFO empty.
- `rdempty_rcf`  in  1  count FIFO empty.
- `dataout_rf`  in  DATA_WIDTH  data FIFO read data, valid 1 cycle after `rden_rf`.
- `dataout_rcf`  in  BCNT_WIDTH  descriptor, valid 1 cycle after `rden_rcf`: [31:16] byte count, [15] MAC error, [14] filter error.
- `rx_axis_mac_tdata`  out  DATA_WIDTH  stream data.
- `rx_axis_mac_tvalid`  out  1  beat valid.
- `rx_axis_mac_tlast`  out  1  last beat of frame.
- `rx_axis_mac_tuser`  out  1  MAC error or oversize; valid on every beat of the frame.
- `rx_axis_filter_tuser`  out  1  filter error; valid on every beat.
- `rx_axis_mac_tstrb`  out  BYTES  byte-valid mask.
- `rx_statistics_vector`  out  28  [15:0] byte count, [16] tuser, [17] filter, [27:18] frame sequence number mod 1024.
- `rx_statistics_valid`  out  1  one-cycle pulse.
- `rx_axis_mac_tready`  in  1  downstream ready.
- `rx_axis_compatible_mode`  in  1  when 1, `tready` is treated internally as constantly 1.
- `rx_zero_len_cnt`  out  16  saturating count of discarded zero-length descriptors.
- `test`  out  1  tied 0.

## Operation
- Effective ready: `rdy = rx_axis_mac_tready | rx_axis_compatible_mode`, used combinationally.
- FSM states: IDLE, CNT, DESC, STREAM.
  - IDLE -> CNT when `!rdempty_rcf`.
  - CNT -> DESC unconditionally. `rden_rcf` = 1 exactly while in CNT.
  - DESC latches the descriptor. If byte count = 0: increment `rx_zero_len_cnt` (saturating at FFFF) and go to IDLE. Otherwise load `beats_left = ceil(bcnt/BYTES)` and go to STREAM.
  - STREAM: `rden_rf = !rdempty_rf & (skid_occupancy + reads_in_flight < 2)`. `beats_left` decrements on each read. When the last read issues, go to IDLE. That read may coincide with IDLE seeing a non-empty count FIFO, so the next frame overlaps.
- Each returned data word enters the skid buffer with per-beat sideband: `tlast` (final beat), `tstrb` (all ones except the final beat, which gets the low `bcnt mod BYTES` bits set, or all ones if 0), `tuser = err | (bcnt > MAX_FRAME_BYTES)`, and `filter`.
- The AXIS beat transfers on `tvalid & rdy`. Data, sideband and `tvalid` stay stable while `tvalid & !rdy`.
- `rx_statistics_valid` pulses in the cycle after the `tlast` handshake. The vector holds until the next pulse. The sequence number increments per emitted frame.
- A data FIFO underflow mid-frame stalls: no read is issued and `tvalid` drops once the buffer drains. No data is fabricated.

## Timing
- Reset value of all outputs is 0, including `rden_*`, `rx_zero_len_cnt` and the sequence number. State goes to IDLE.
- Reset asserted mid-frame aborts immediately. Consumed FIFO words are lost. After release the block resynchronises on the next descriptor; that re-alignment is the FIFO owner's responsibility.
- Latency, idle with FIFOs primed: `!rdempty_rcf` seen at cycle N, `rden_rcf` at N+1, descriptor latched at N+2, first `rden_rf` at N+3, first `tvalid` at N+5.
- With `rdy` = 1 and a non-empty data FIFO: one beat per cycle sustained. The inter-frame gap is ≤3 cycles.
- After `rdy` deasserts, at most 2 further FIFO reads can land; the skid buffer never overflows.

## Structure
- Package `axis2fib_pkg`:
  - FSM state enum.
  - Descriptor field positions: `BCNT_HI = 31`, `BCNT_LO = 16`, `ERR_BIT = 15`, `FILT_BIT = 14`.
  - Function `last_strb(bcnt, BYTES)`.
  - Statistics vector field offsets.
- Sub-module `axis2fib_skid_buf`: 2-entry FIFO carrying `{tdata, tstrb, tlast, tuser, filter}` with an AXIS ready/valid output.

## Test plan
- DATA_WIDTH=64, bcnt=20, `rdy`=1 -> 3 beats, `tstrb` FF, FF, 0F; `tlast` on beat 3; stats pulse with vector[15:0] = 0x0014.
- DATA_WIDTH=128, bcnt=64 -> 4 beats, all `tstrb` FFFF; first `tvalid` exactly 5 cycles after `rdempty_rcf` falls.
- bcnt=24, `tready` toggling 1/0 every cycle -> 3 beats, data stable during stalls, no loss or duplication, never more than 2 reads outstanding beyond the buffer.
- Descriptor err=1, bcnt=10000 -> `tuser`=1 on all beats, stats bit 16 = 1; bcnt=0 descriptor -> no beats, `rx_zero_len_cnt` = 1.
- Two queued frames, bcnt 16 and 8, `rdy`=1 -> 3 beats total, gap ≤3 cycles, sequence numbers 0 and 1; then `reset_` low mid-frame -> all outputs 0 asynchronously.
